// File: rtl/lift_sweep_pkg.sv
// Shared types and helpers for the lifted-boundary sweep harnesses.
package lift_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    // Width of the settle counter; covers hold windows of 1..255 cycles.
    localparam int SETTLE_W = 8;

    // Highest stimulus of an n-input sweep (all ones).
    function automatic logic [31:0] last_vector(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/lift_settle_timer.sv
// Load-and-count settle timer: clear restarts the count, enable advances it,
// and expire marks the CYCLES-th enabled edge since the last clear.
module lift_settle_timer
    import lift_sweep_pkg::*;
#(
    parameter int unsigned CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [SETTLE_W-1:0] LIMIT = SETTLE_W'(CYCLES - 1);

    logic [SETTLE_W-1:0] cnt;

    // Expiry is decoded from the count so the owner can act on the same edge.
    assign expire = enable && !clear && (cnt == LIMIT);

    // Count enabled edges, wrapping to zero on expiry so back-to-back windows work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (expire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + SETTLE_W'(1);
            end
        end
    end

endmodule

// File: rtl/lift_boundary_sweeper.sv
// Exhaustive stimulus/capture stage for the lifted boundary of a partial
// circuit: walks lifted_input through 0..2^N-1, holds each value for a settle
// window, captures lifted_output and hands the pair downstream on valid/ready.
module lift_boundary_sweeper
    import lift_sweep_pkg::*;
#(
    parameter int unsigned N_LIFT_IN     = 2,
    parameter int unsigned N_LIFT_OUT    = 1,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESETN,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [N_LIFT_IN-1:0]  lifted_input,
    input  logic [N_LIFT_OUT-1:0] lifted_output,
    output logic                  O_valid,
    input  logic                  O_ready,
    output logic [N_LIFT_IN-1:0]  O_stim,
    output logic [N_LIFT_OUT-1:0] O_resp,
    output logic                  O_last
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("lift_boundary_sweeper: SETTLE_CYCLES must be 1..255");
    end
    if (N_LIFT_IN < 1 || N_LIFT_IN > 8) begin : g_bad_in
        $error("lift_boundary_sweeper: N_LIFT_IN must be 1..8");
    end
    if (N_LIFT_OUT < 1 || N_LIFT_OUT > 32) begin : g_bad_out
        $error("lift_boundary_sweeper: N_LIFT_OUT must be 1..32");
    end

    localparam logic [N_LIFT_IN-1:0] LAST_VEC = N_LIFT_IN'(last_vector(N_LIFT_IN));

    sweep_state_t          state;
    sweep_state_t          next_state;
    logic [N_LIFT_IN-1:0]  vector;
    logic [N_LIFT_IN-1:0]  next_vector;
    logic [N_LIFT_OUT-1:0] resp;
    logic                  capture;
    logic                  timer_clear;
    logic                  timer_en;
    logic                  expire;
    logic                  at_last;

    // The stimulus and the presented pair come straight from registers, so the
    // partial never sees a glitch and no input reaches an output combinationally.
    assign lifted_input = vector;
    assign O_stim       = vector;
    assign O_resp       = resp;

    assign timer_en = (state == SETTLE);
    assign at_last  = (vector == LAST_VEC);

    lift_settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk    (CLK),
        .rst_n  (ASYNCRESETN),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (expire)
    );

    // Next-state and datapath control; the sweep ends on the all-ones pair,
    // never on counter overflow.
    always_comb begin
        next_state  = state;
        next_vector = vector;
        capture     = 1'b0;
        timer_clear = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_vector = '0;
                    timer_clear = 1'b1;
                    next_state  = SETTLE;
                end
            end
            SETTLE: begin
                if (expire) begin
                    capture    = 1'b1;
                    next_state = EMIT;
                end
            end
            EMIT: begin
                if (O_ready) begin
                    if (at_last) begin
                        next_state = DONE;
                    end else begin
                        next_vector = vector + N_LIFT_IN'(1);
                        timer_clear = 1'b1;
                        next_state  = SETTLE;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register; reset aborts any sweep in progress immediately.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stimulus, captured response and registered status flags, all derived
    // from the upcoming state so each output is a flop.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            vector  <= '0;
            resp    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            O_valid <= 1'b0;
            O_last  <= 1'b0;
        end else begin
            vector  <= next_vector;
            if (capture) begin
                resp <= lifted_output;
            end
            busy    <= (next_state != IDLE);
            done    <= (next_state == DONE);
            O_valid <= (next_state == EMIT);
            O_last  <= (next_state == EMIT) && (next_vector == LAST_VEC);
        end
    end

endmodule

// File: tb/tb_lift_boundary_sweeper.sv
// Scoreboard bench for lift_boundary_sweeper: three configurations, expected
// pairs queued at stimulus time and popped by per-instance monitors.
module tb_lift_boundary_sweeper;

    logic clk;
    logic rst_n;
    logic force0;

    logic       start_a, busy_a, done_a, valid_a, ready_a, last_a;
    logic [1:0] li_a, stim_a;
    logic [0:0] lo_a, resp_a;

    logic       start_b, busy_b, done_b, valid_b, ready_b, last_b;
    logic [1:0] li_b, stim_b;
    logic [0:0] lo_b, resp_b;

    logic       start_c, busy_c, done_c, valid_c, ready_c, last_c;
    logic [2:0] li_c, stim_c;
    logic [1:0] lo_c, resp_c;
    logic [1:0] tbl_c [0:7];

    logic [16:0] qa[$];
    logic [16:0] qb[$];
    logic [16:0] qc[$];
    logic [16:0] ea, eb, ec;
    logic        edone_a, edone_b, edone_c;

    int n_cmp;
    int n_err;

    // Partial models: 2-input OR (with a stall-time override) and a lookup table.
    assign lo_a = force0 ? 1'b0 : (li_a[0] | li_a[1]);
    assign lo_b = li_b[0] | li_b[1];
    assign lo_c = tbl_c[li_c];

    lift_boundary_sweeper #(.N_LIFT_IN(2), .N_LIFT_OUT(1), .SETTLE_CYCLES(1)) dut_a (
        .CLK(clk), .ASYNCRESETN(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .lifted_input(li_a), .lifted_output(lo_a), .O_valid(valid_a), .O_ready(ready_a),
        .O_stim(stim_a), .O_resp(resp_a), .O_last(last_a)
    );

    lift_boundary_sweeper #(.N_LIFT_IN(2), .N_LIFT_OUT(1), .SETTLE_CYCLES(3)) dut_b (
        .CLK(clk), .ASYNCRESETN(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .lifted_input(li_b), .lifted_output(lo_b), .O_valid(valid_b), .O_ready(ready_b),
        .O_stim(stim_b), .O_resp(resp_b), .O_last(last_b)
    );

    lift_boundary_sweeper #(.N_LIFT_IN(3), .N_LIFT_OUT(2), .SETTLE_CYCLES(2)) dut_c (
        .CLK(clk), .ASYNCRESETN(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
        .lifted_input(li_c), .lifted_output(lo_c), .O_valid(valid_c), .O_ready(ready_c),
        .O_stim(stim_c), .O_resp(resp_c), .O_last(last_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic extra(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: pair presented with empty scoreboard", nm);
    endtask

    task automatic push_pair(input int sel, input int stim, input int resp, input bit last);
        logic [16:0] e;
        e = {last, 8'(stim), 8'(resp)};
        case (sel)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic push_or(input int sel);
        push_pair(sel, 0, 0, 1'b0);
        push_pair(sel, 1, 1, 1'b0);
        push_pair(sel, 2, 1, 1'b0);
        push_pair(sel, 3, 1, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit probe(input int sel);
        case (sel)
            0: return done_a;
            1: return done_b;
            2: return done_c;
            3: return valid_a && (stim_a == 2'd1);
            4: return valid_a && (stim_a == 2'd2);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string nm);
        int n;
        n = 0;
        while (!probe(sel) && n < 400) begin
            tick();
            n++;
        end
        check(nm, 32'(probe(sel)), 32'd1);
    endtask

    // Monitor A: pop on handshake, and require done exactly one cycle after the last accept.
    always @(negedge clk) begin
        if (valid_a && ready_a) begin
            if (qa.size() == 0) begin
                extra("a_extra_pair");
            end else begin
                ea = qa.pop_front();
                check("a_stim", 32'(stim_a), 32'(ea[15:8]));
                check("a_resp", 32'(resp_a), 32'(ea[7:0]));
                check("a_last", 32'(last_a), 32'(ea[16]));
            end
        end
        if (done_a || edone_a) check("a_done", 32'(done_a), 32'(edone_a));
        edone_a = valid_a && ready_a && last_a;
    end

    // Monitor B.
    always @(negedge clk) begin
        if (valid_b && ready_b) begin
            if (qb.size() == 0) begin
                extra("b_extra_pair");
            end else begin
                eb = qb.pop_front();
                check("b_stim", 32'(stim_b), 32'(eb[15:8]));
                check("b_resp", 32'(resp_b), 32'(eb[7:0]));
                check("b_last", 32'(last_b), 32'(eb[16]));
            end
        end
        if (done_b || edone_b) check("b_done", 32'(done_b), 32'(edone_b));
        edone_b = valid_b && ready_b && last_b;
    end

    // Monitor C.
    always @(negedge clk) begin
        if (valid_c && ready_c) begin
            if (qc.size() == 0) begin
                extra("c_extra_pair");
            end else begin
                ec = qc.pop_front();
                check("c_stim", 32'(stim_c), 32'(ec[15:8]));
                check("c_resp", 32'(resp_c), 32'(ec[7:0]));
                check("c_last", 32'(last_c), 32'(ec[16]));
            end
        end
        if (done_c || edone_c) check("c_done", 32'(done_c), 32'(edone_c));
        edone_c = valid_c && ready_c && last_c;
    end

    // Hard stop in case the stimulus itself wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int n;
        clk = 0; rst_n = 0; force0 = 0;
        start_a = 0; start_b = 0; start_c = 0;
        ready_a = 1; ready_b = 1; ready_c = 1;
        edone_a = 0; edone_b = 0; edone_c = 0;
        n_cmp = 0; n_err = 0;
        tbl_c[0] = 2'd2; tbl_c[1] = 2'd0; tbl_c[2] = 2'd3; tbl_c[3] = 2'd1;
        tbl_c[4] = 2'd1; tbl_c[5] = 2'd2; tbl_c[6] = 2'd0; tbl_c[7] = 2'd3;

        // Reset state.
        #12;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_last", 32'(last_a), 32'd0);
        check("rst_li", 32'(li_a), 32'd0);
        check("rst_stim", 32'(stim_a), 32'd0);
        check("rst_resp", 32'(resp_a), 32'd0);
        check("rst_c_valid", 32'(valid_c), 32'd0);
        check("rst_c_li", 32'(li_c), 32'd0);
        #10 rst_n = 1;
        tick();

        // OR partial, S=1, ready high: done occupies the 9th cycle after the start edge.
        push_or(0);
        start_a = 1; tick(); start_a = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_a && n < 100);
        check("a_done_cycle", 32'(n), 32'd9);
        tick(); tick(); tick();
        check("a_sweep1_drained", 32'(qa.size()), 32'd0);
        check("a_idle_after", 32'(busy_a), 32'd0);

        // S=3: first valid exactly 3 edges after the start edge, stimulus held at 0.
        push_or(1);
        start_b = 1; tick(); start_b = 0;
        check("b_busy", 32'(busy_b), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("b_first_valid", 32'(valid_b), 32'(k == 3));
            check("b_li_hold", 32'(li_b), 32'd0);
        end
        wait_for(1, "b_done_seen");
        tick(); tick();
        check("b_drained", 32'(qb.size()), 32'd0);

        // Backpressure on stim=1, with the partial output pulled low mid-stall.
        push_or(0);
        start_a = 1; tick(); start_a = 0;
        wait_for(3, "a_reach_stim1");
        ready_a = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(valid_a), 32'd1);
            check("stall_stim", 32'(stim_a), 32'd1);
            check("stall_resp", 32'(resp_a), 32'd1);
            check("stall_li", 32'(li_a), 32'd1);
            if (i == 1) force0 = 1;
            tick();
        end
        force0 = 0;
        ready_a = 1;
        wait_for(0, "a_stall_done_seen");
        tick(); tick();
        check("a_stall_drained", 32'(qa.size()), 32'd0);

        // start held high through SETTLE, EMIT and DONE: one sweep, one done.
        push_or(0);
        start_a = 1; tick();
        wait_for(0, "a_busy_start_done_seen");
        tick();
        start_a = 0;
        tick(); tick(); tick();
        check("a_no_restart", 32'(busy_a), 32'd0);
        check("a_busy_start_drained", 32'(qa.size()), 32'd0);

        // Asynchronous reset while stim=2 is presented, then a clean restart.
        push_or(0);
        start_a = 1; tick(); start_a = 0;
        wait_for(4, "a_reach_stim2");
        #2 rst_n = 0;
        #1;
        check("arst_valid", 32'(valid_a), 32'd0);
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_li", 32'(li_a), 32'd0);
        check("arst_stim", 32'(stim_a), 32'd0);
        qa.delete();
        #10 rst_n = 1;
        tick();
        push_or(0);
        start_a = 1; tick(); start_a = 0;
        wait_for(0, "a_restart_done_seen");
        tick(); tick();
        check("a_restart_drained", 32'(qa.size()), 32'd0);

        // N=3, two outputs, S=2 against the lookup-table partial.
        push_pair(2, 0, 2, 1'b0);
        push_pair(2, 1, 0, 1'b0);
        push_pair(2, 2, 3, 1'b0);
        push_pair(2, 3, 1, 1'b0);
        push_pair(2, 4, 1, 1'b0);
        push_pair(2, 5, 2, 1'b0);
        push_pair(2, 6, 0, 1'b0);
        push_pair(2, 7, 3, 1'b1);
        start_c = 1; tick(); start_c = 0;
        wait_for(2, "c_done_seen");
        tick(); tick();
        check("c_drained", 32'(qc.size()), 32'd0);
        check("c_idle_after", 32'(busy_c), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
